i_execute: RTL and testbench

- LEGv8 single-issue Execute (EX) stage.
- Selects the ALU second operand, decodes ALU control from alu_op/opcode, computes alu_result and the zero flag, and computes branch_target = cur_pc + (offset << 2).
- All outputs are registered: the block forms the EX-side output register feeding the Memory stage.

---
 rtl/i_execute.sv | 115 +++++++++++
 tb/tb_i_execute.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/i_execute.sv
// rtl/i_execute.sv - LEGv8 execute stage: operand B mux, ALU control decode, ALU, branch target, EX/MEM output register.
// Optional EXECUTE_EXT_ALU_EN adds R-type EOR, LSL and LSR.
module i_execute #(
   parameter int WORD = 64
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [WORD-1:0] cur_pc,
   input  logic [WORD-1:0] read_data1,
   input  logic [WORD-1:0] read_data2,
   input  logic [WORD-1:0] sign_extended_output,
   input  logic [1:0]      alu_op,
   input  logic            alu_src,
   input  logic [10:0]     opcode,
   output logic [WORD-1:0] branch_target,
   output logic [WORD-1:0] alu_result,
   output logic            zero
);

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_ORR,
      ALU_PASS_B,
      ALU_NONE,
      ALU_EOR,
      ALU_LSL,
      ALU_LSR
   } alu_ctl_e;

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
`ifdef EXECUTE_EXT_ALU_EN
   localparam logic [10:0] OPC_EOR = 11'b11001010000;
   localparam logic [10:0] OPC_LSL = 11'b11010011011;
   localparam logic [10:0] OPC_LSR = 11'b11010011010;
`endif

   alu_ctl_e        alu_ctl;
   logic [WORD-1:0] op_b;
   logic [WORD-1:0] alu_res;

   logic [WORD-1:0] branch_target_d, branch_target_q;
   logic [WORD-1:0] alu_result_d, alu_result_q;
   logic            zero_d, zero_q;

   assign op_b = alu_src ? sign_extended_output : read_data2;

   always_comb begin
      alu_ctl = ALU_NONE;
      case (alu_op)
         2'b00: alu_ctl = ALU_ADD;
         2'b01: alu_ctl = ALU_PASS_B;
         2'b11: alu_ctl = ALU_PASS_B;
         default: begin
            case (opcode)
               OPC_ADD: alu_ctl = ALU_ADD;
               OPC_SUB: alu_ctl = ALU_SUB;
               OPC_AND: alu_ctl = ALU_AND;
               OPC_ORR: alu_ctl = ALU_ORR;
`ifdef EXECUTE_EXT_ALU_EN
               OPC_EOR: alu_ctl = ALU_EOR;
               OPC_LSL: alu_ctl = ALU_LSL;
               OPC_LSR: alu_ctl = ALU_LSR;
`endif
               default: alu_ctl = ALU_NONE;
            endcase
         end
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (alu_ctl)
         ALU_ADD:    alu_res = read_data1 + op_b;
         ALU_SUB:    alu_res = read_data1 - op_b;
         ALU_AND:    alu_res = read_data1 & op_b;
         ALU_ORR:    alu_res = read_data1 | op_b;
         ALU_PASS_B: alu_res = op_b;
`ifdef EXECUTE_EXT_ALU_EN
         ALU_EOR:    alu_res = read_data1 ^ op_b;
         ALU_LSL:    alu_res = read_data1 << op_b[5:0];
         ALU_LSR:    alu_res = read_data1 >> op_b[5:0];
`endif
         default:    alu_res = '0;
      endcase
   end

   // Branch offsets arrive in word units; the top two bits fall off in the shift.
   always_comb begin
      branch_target_d = cur_pc + {sign_extended_output[WORD-3:0], 2'b00};
      alu_result_d    = alu_res;
      zero_d          = (alu_res == '0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         branch_target_q <= '0;
         alu_result_q    <= '0;
         zero_q          <= 1'b0;
      end else begin
         branch_target_q <= branch_target_d;
         alu_result_q    <= alu_result_d;
         zero_q          <= zero_d;
      end
   end

   assign branch_target = branch_target_q;
   assign alu_result    = alu_result_q;
   assign zero          = zero_q;

endmodule

// File: tb/tb_i_execute.sv
// tb/tb_i_execute.sv - directed self-checking bench for i_execute.
module tb_i_execute;

   logic        clk;
   logic        rst_n;
   logic [63:0] cur_pc;
   logic [63:0] read_data1;
   logic [63:0] read_data2;
   logic [63:0] sign_extended_output;
   logic [1:0]  alu_op;
   logic        alu_src;
   logic [10:0] opcode;
   logic [63:0] branch_target;
   logic [63:0] alu_result;
   logic        zero;

   int tests_run;
   int tests_failed;

   i_execute #(.WORD(64)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .cur_pc               (cur_pc),
      .read_data1           (read_data1),
      .read_data2           (read_data2),
      .sign_extended_output (sign_extended_output),
      .alu_op               (alu_op),
      .alu_src              (alu_src),
      .opcode               (opcode),
      .branch_target        (branch_target),
      .alu_result           (alu_result),
      .zero                 (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   task automatic apply(input logic [63:0] pc, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] imm, input logic [1:0] op, input logic src,
                        input logic [10:0] opc);
      cur_pc               = pc;
      read_data1           = a;
      read_data2           = b;
      sign_extended_output = imm;
      alu_op               = op;
      alu_src              = src;
      opcode               = opc;
      @(posedge clk);
      #1;
   endtask

   localparam logic [10:0] OPC_ADD = 11'b10001011000;
   localparam logic [10:0] OPC_SUB = 11'b11001011000;
   localparam logic [10:0] OPC_AND = 11'b10001010000;
   localparam logic [10:0] OPC_ORR = 11'b10101010000;
   localparam logic [10:0] OPC_EOR = 11'b11001010000;
   localparam logic [10:0] OPC_LSL = 11'b11010011011;
   localparam logic [10:0] OPC_LSR = 11'b11010011010;

   initial begin
      tests_run    = 0;
      tests_failed = 0;

      rst_n = 1'b0;
      apply(64'd100, 64'd7, 64'd9, 64'd3, 2'b10, 1'b0, OPC_ADD);
      apply(64'd100, 64'd7, 64'd9, 64'd3, 2'b10, 1'b0, OPC_ADD);
      check("reset_bt", branch_target, 64'd0);
      check("reset_res", alu_result, 64'd0);
      check("reset_zero", {63'd0, zero}, 64'd0);
      rst_n = 1'b1;

      apply(64'd0, 64'd16, 64'd0, 64'd64, 2'b00, 1'b1, 11'd0);
      check("ldur_res", alu_result, 64'd80);
      check("ldur_zero", {63'd0, zero}, 64'd0);
      check("ldur_bt", branch_target, 64'd256);

      apply(64'd4, 64'd10, 64'd20, 64'd88, 2'b10, 1'b0, OPC_ADD);
      check("add_res", alu_result, 64'd30);
      check("add_zero", {63'd0, zero}, 64'd0);
      check("add_bt", branch_target, 64'd356);

      apply(64'd8, 64'd30, 64'd30, 64'd0, 2'b10, 1'b0, OPC_SUB);
      check("sub_res", alu_result, 64'd0);
      check("sub_zero", {63'd0, zero}, 64'd1);

      apply(64'd12, 64'd16, 64'd5, 64'd96, 2'b00, 1'b1, 11'd0);
      check("stur_res", alu_result, 64'd112);
      check("stur_zero", {63'd0, zero}, 64'd0);
      check("stur_bt", branch_target, 64'd396);

      apply(64'd16, 64'd55, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 2'b01, 1'b0, 11'd0);
      check("cbz_res", alu_result, 64'd0);
      check("cbz_zero", {63'd0, zero}, 64'd1);
      check("cbz_bt", branch_target, 64'hFFFF_FFFF_FFFF_FFFC);

      apply(64'd16, 64'd55, 64'd20, 64'hFFFF_FFFF_FFFF_FFFB, 2'b01, 1'b0, 11'd0);
      check("cbz_nz_res", alu_result, 64'd20);
      check("cbz_nz_zero", {63'd0, zero}, 64'd0);

      apply(64'd20, 64'd30, 64'd0, 64'd1, 2'b10, 1'b0, OPC_ORR);
      check("orr_res", alu_result, 64'd30);

      apply(64'd24, 64'd16, 64'd30, 64'd1, 2'b10, 1'b0, OPC_AND);
      check("and_res", alu_result, 64'd16);

      apply(64'd28, 64'd3, 64'd4, 64'hFFFF_FFFF_FFFF_FFC9, 2'b11, 1'b1, 11'd0);
      check("b_bt", branch_target, 64'hFFFF_FFFF_FFFF_FF40);
      check("b_res", alu_result, 64'hFFFF_FFFF_FFFF_FFC9);

      apply(64'd32, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 2'b10, 1'b0, OPC_ADD);
      check("add_wrap_res", alu_result, 64'd0);
      check("add_wrap_zero", {63'd0, zero}, 64'd1);

      apply(64'd36, 64'd0, 64'd1, 64'd0, 2'b10, 1'b0, OPC_SUB);
      check("sub_wrap_res", alu_result, 64'hFFFF_FFFF_FFFF_FFFF);

      apply(64'd40, 64'd5, 64'd6, 64'd0, 2'b10, 1'b0, 11'b11111111111);
      check("unk_res", alu_result, 64'd0);
      check("unk_zero", {63'd0, zero}, 64'd1);

`ifdef EXECUTE_EXT_ALU_EN
      apply(64'd44, 64'hF0, 64'hFF, 64'd0, 2'b10, 1'b0, OPC_EOR);
      check("eor_res", alu_result, 64'h0F);
      check("eor_zero", {63'd0, zero}, 64'd0);
      apply(64'd48, 64'd3, 64'd4, 64'd0, 2'b10, 1'b0, OPC_LSL);
      check("lsl_res", alu_result, 64'd48);
      apply(64'd52, 64'h80, 64'd3, 64'd0, 2'b10, 1'b0, OPC_LSR);
      check("lsr_res", alu_result, 64'h10);
`else
      apply(64'd44, 64'hF0, 64'hFF, 64'd0, 2'b10, 1'b0, OPC_EOR);
      check("eor_res", alu_result, 64'd0);
      check("eor_zero", {63'd0, zero}, 64'd1);
      apply(64'd48, 64'd3, 64'd4, 64'd0, 2'b10, 1'b0, OPC_LSL);
      check("lsl_res", alu_result, 64'd0);
      apply(64'd52, 64'h80, 64'd3, 64'd0, 2'b10, 1'b0, OPC_LSR);
      check("lsr_res", alu_result, 64'd0);
`endif

      rst_n = 1'b0;
      apply(64'd200, 64'd10, 64'd20, 64'd8, 2'b10, 1'b0, OPC_ADD);
      check("rst2_bt", branch_target, 64'd0);
      check("rst2_res", alu_result, 64'd0);
      check("rst2_zero", {63'd0, zero}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
